// File: rtl/sram_ctrl_256x288.sv
// sram_ctrl_256x288: request front-end for a 256x288 masked single-port SRAM
// (32 lanes of 9 bits) with an in-order read response FIFO.
// Optional feature: define SRAM_PARITY_EN for per-byte even parity generation,
// checking and a saturating error counter.
module sram_ctrl_256x288 #(
    parameter int RSP_DEPTH = 2
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [7:0]   req_addr,
    input  logic [255:0] req_wdata,
    input  logic [31:0]  req_wmask,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [255:0] rsp_rdata,
    output logic [31:0]  rsp_perr,
    output logic [7:0]   perr_count,
    output logic         sram_valid,
    output logic         sram_write,
    output logic [7:0]   sram_addr,
    output logic [287:0] sram_wdata,
    output logic [31:0]  sram_wmask,
    input  logic [287:0] sram_rdata
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic          accept;
    logic          push;
    logic          pop;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [255:0]  rd_bytes;
    logic [31:0]   wr_par;
    logic [255:0]  data_mem [RSP_DEPTH];

    // Ready counts the read already issued to the SRAM so the FIFO can never
    // overflow; it looks only at registered state, so a pop frees a slot one
    // cycle later.
    assign req_ready  = resetn && ((count_q + CW'(inflight_q)) < DEPTH_C);
    assign accept     = req_valid & req_ready;
    assign sram_valid = accept;
    assign sram_write = req_write;
    assign sram_addr  = req_addr;
    assign sram_wmask = req_wmask;

    // SRAM read data returns the cycle after issue and goes straight in the FIFO
    assign push      = inflight_q;
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = data_mem[rptr_q];

    // Byte lanes map onto the low 8 bits of each 9-bit SRAM lane
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_lane
            assign sram_wdata[9*gi +: 8] = req_wdata[8*gi +: 8];
            assign sram_wdata[9*gi + 8]  = wr_par[gi];
            assign rd_bytes[8*gi +: 8]   = sram_rdata[9*gi +: 8];
        end
    endgenerate

`ifdef SRAM_PARITY_EN
    logic [31:0] rd_perr;
    logic [31:0] perr_mem [RSP_DEPTH];
    logic [7:0]  perr_count_q, perr_count_d;

    // Even parity: stored ninth bit makes each 9-bit lane XOR to zero
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_par
            assign wr_par[gi]  = ^req_wdata[8*gi +: 8];
            assign rd_perr[gi] = ^sram_rdata[9*gi +: 9];
        end
    endgenerate

    // Count pushed responses that carry any lane error, saturating at 255
    always_comb begin
        perr_count_d = perr_count_q;
        if (push && (rd_perr != '0) && (perr_count_q != 8'hFF)) begin
            perr_count_d = perr_count_q + 8'd1;
        end
    end

    // Error counter register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perr_count_q <= '0;
        end else begin
            perr_count_q <= perr_count_d;
        end
    end

    // Error flags travel with the data entry
    always_ff @(posedge clock) begin
        if (push) begin
            perr_mem[wptr_q] <= rd_perr;
        end
    end

    assign rsp_perr   = perr_mem[rptr_q];
    assign perr_count = perr_count_q;
`else
    logic [31:0] unused_par;

    // Lane parity bits from the SRAM are deliberately dropped
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_nopar
            assign unused_par[gi] = sram_rdata[9*gi + 8];
        end
    endgenerate

    assign wr_par     = '0;
    assign rsp_perr   = '0;
    assign perr_count = '0;
`endif

    // Next-state for in-flight flag, FIFO pointers and occupancy
    always_comb begin
        inflight_d = accept & ~req_write;
        wptr_d     = wptr_q + PW'(push);
        rptr_d     = rptr_q + PW'(pop);
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers; reset discards any buffered or pending read
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Response data storage
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wptr_q] <= rd_bytes;
        end
    end

endmodule

// File: tb/tb_sram_ctrl_256x288.sv
// Testbench for sram_ctrl_256x288: behavioural SRAM, byte-level reference
// model checked every cycle, a directed vector table and corner sequences.
module tb_sram_ctrl_256x288;
    localparam int DEPTH = 2;
`ifdef SRAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [7:0]   req_addr = '0;
    logic [255:0] req_wdata = '0;
    logic [31:0]  req_wmask = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [255:0] rsp_rdata;
    logic [31:0]  rsp_perr;
    logic [7:0]   perr_count;
    logic         sram_valid;
    logic         sram_write;
    logic [7:0]   sram_addr;
    logic [287:0] sram_wdata;
    logic [31:0]  sram_wmask;
    logic [287:0] sram_rdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit flip_req = 1'b0;

    always #5 clock = ~clock;

    sram_ctrl_256x288 #(.RSP_DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_perr(rsp_perr), .perr_count(perr_count),
        .sram_valid(sram_valid), .sram_write(sram_write), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
    );

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Behavioural masked SRAM: 9-bit lanes, read data held until next read
    logic [287:0] sram_mem [256];
    logic [287:0] sram_rd_r;
    logic [287:0] sram_w;
    assign sram_rdata = sram_rd_r;
    always @(posedge clock) begin
        if (sram_valid) begin
            if (sram_write) begin
                sram_w = sram_mem[sram_addr];
                for (int i = 0; i < 32; i++)
                    if (sram_wmask[i]) sram_w[9*i +: 9] = sram_wdata[9*i +: 9];
                sram_mem[sram_addr] <= sram_w;
            end else begin
                sram_rd_r <= sram_mem[sram_addr] ^ (flip_req ? (288'd1 << 27) : 288'd0);
            end
        end
    end

    // Reference model: byte memory plus queue of outstanding read responses
    typedef struct {
        logic [255:0] data;
        logic [31:0]  perr;
        int           avail;
    } rsp_t;
    logic [7:0] ref_mem [256][32];
    rsp_t rq[$];
    int perr_ev[$];
    int ref_pcnt = 0;

    always @(negedge clock) begin
        bit exp_ready;
        bit exp_rv;
        logic [287:0] exp_w;
        logic [255:0] d;
        rsp_t e;
        if (!resetn) begin
            rq.delete();
            perr_ev.delete();
            ref_pcnt = 0;
            chk("rst_req_ready", 288'(req_ready), 288'(0));
            chk("rst_rsp_valid", 288'(rsp_valid), 288'(0));
            chk("rst_sram_valid", 288'(sram_valid), 288'(0));
            chk("rst_perr_count", 288'(perr_count), 288'(0));
        end else begin
            while (perr_ev.size() > 0 && perr_ev[0] <= cyc) begin
                void'(perr_ev.pop_front());
                if (ref_pcnt < 255) ref_pcnt++;
            end
            exp_ready = (rq.size() < DEPTH);
            exp_rv    = (rq.size() > 0) && (rq[0].avail <= cyc);
            chk("req_ready", 288'(req_ready), 288'(exp_ready));
            chk("rsp_valid", 288'(rsp_valid), 288'(exp_rv));
            chk("sram_valid", 288'(sram_valid), 288'(req_valid && exp_ready));
            chk("perr_count", 288'(perr_count), 288'(ref_pcnt));
            if (exp_rv) begin
                chk("rsp_rdata", 288'(rsp_rdata), 288'(rq[0].data));
                chk("rsp_perr", 288'(rsp_perr), 288'(rq[0].perr));
            end
            if (exp_rv && rsp_ready) void'(rq.pop_front());
            if (req_valid && exp_ready) begin
                chk("sram_write", 288'(sram_write), 288'(req_write));
                chk("sram_addr", 288'(sram_addr), 288'(req_addr));
                chk("sram_wmask", 288'(sram_wmask), 288'(req_wmask));
                if (req_write) begin
                    for (int i = 0; i < 32; i++) begin
                        exp_w[9*i +: 8] = req_wdata[8*i +: 8];
                        exp_w[9*i + 8]  = PAR ? ^req_wdata[8*i +: 8] : 1'b0;
                        if (req_wmask[i]) ref_mem[req_addr][i] = req_wdata[8*i +: 8];
                    end
                    chk("sram_wdata", sram_wdata, exp_w);
                    $display("txn cyc=%0d WR addr=%02h mask=%08h", cyc, req_addr, req_wmask);
                end else begin
                    for (int i = 0; i < 32; i++) d[8*i +: 8] = ref_mem[req_addr][i];
                    e.perr = 32'h0;
                    if (flip_req) begin
                        d[24] = ~d[24];
                        e.perr = PAR ? 32'h8 : 32'h0;
                    end
                    e.data  = d;
                    e.avail = cyc + 2;
                    rq.push_back(e);
                    if (e.perr != 32'h0) perr_ev.push_back(cyc + 2);
                    $display("txn cyc=%0d RD addr=%02h flip=%0d", cyc, req_addr, flip_req);
                end
            end
        end
        cyc++;
    end

    // Drive one request and hold it until accepted (bounded)
    task automatic issue(input bit wr, input logic [7:0] a, input logic [255:0] wd,
                         input logic [31:0] m, input bit fl);
        bit got;
        got = 1'b0;
        req_valid = 1'b1; req_write = wr; req_addr = a;
        req_wdata = wd; req_wmask = m; flip_req = fl;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clock);
            if (req_ready) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL accept_timeout addr=%02h act=0 exp=1", a);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        flip_req = 1'b0;
    endtask

    // Wait (bounded) for a response, returning cycles since acceptance
    task automatic wait_rsp(output int lat);
        bit seen;
        seen = 1'b0;
        lat = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            lat++;
            if (rsp_valid) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL rsp_timeout act=0 exp=1");
        end
    endtask

    typedef struct {
        bit           wr;
        logic [7:0]   addr;
        logic [255:0] wdata;
        logic [31:0]  wmask;
        logic [255:0] exp;
    } vec_t;
    vec_t tbl[7];
    logic [255:0] inc;
    logic [255:0] mix;

    initial begin
        int lat;
        for (int a = 0; a < 256; a++) begin
            sram_mem[a] = '0;
            for (int i = 0; i < 32; i++) ref_mem[a][i] = 8'h00;
        end
        sram_rd_r = '0;
        for (int i = 0; i < 32; i++) inc[8*i +: 8] = 8'(i);
        mix = {{16{8'hAA}}, {16{8'h55}}};
        tbl[0] = '{1'b1, 8'h10, inc,             32'hFFFFFFFF, '0};
        tbl[1] = '{1'b0, 8'h10, '0,              32'h0,        inc};
        tbl[2] = '{1'b1, 8'h20, {32{8'hAA}},     32'hFFFFFFFF, '0};
        tbl[3] = '{1'b1, 8'h20, {32{8'h55}},     32'h0000FFFF, '0};
        tbl[4] = '{1'b0, 8'h20, '0,              32'h0,        mix};
        tbl[5] = '{1'b1, 8'h30, {32{8'hFF}},     32'h00000001, '0};
        tbl[6] = '{1'b0, 8'h30, '0,              32'h0,        256'hFF};

        // Reset held, then release
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", 288'(req_ready), 288'(1));
        chk("post_rst_rsp_valid", 288'(rsp_valid), 288'(0));
        @(posedge clock); #1;

        // Directed vector table; each write is followed immediately by the next entry
        rsp_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            issue(tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].wmask, 1'b0);
            if (!tbl[v].wr) begin
                wait_rsp(lat);
                chk("tbl_latency", 288'(lat), 288'(2));
                chk("tbl_rdata", 288'(rsp_rdata), 288'(tbl[v].exp));
                chk("tbl_perr", 288'(rsp_perr), 288'(0));
                @(posedge clock); #1;
            end
        end

        // Backpressure: only DEPTH reads accepted while rsp_ready is low
        rsp_ready = 1'b0;
        issue(1'b0, 8'h10, '0, '0, 1'b0);
        issue(1'b0, 8'h20, '0, '0, 1'b0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("bp_ready_low", 288'(req_ready), 288'(0));
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("bp_first_rsp", 288'(rsp_rdata), 288'(inc));
        @(posedge clock); #1;
        @(negedge clock);
        chk("bp_second_rsp", 288'(rsp_rdata), 288'(mix));
        @(posedge clock); #1;
        @(negedge clock);
        chk("bp_ready_back", 288'(req_ready), 288'(1));
        @(posedge clock); #1;

        // Randomized traffic against the reference model
        for (int c = 0; c < 300; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 8'($urandom_range(0, 15));
            for (int w = 0; w < 8; w++) req_wdata[32*w +: 32] = $urandom();
            req_wmask = $urandom();
            flip_req  = ($urandom_range(0, 7) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock); #1;
        end
        req_valid = 1'b0; flip_req = 1'b0; rsp_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;

        // Reset the cycle after a read issues: the read must vanish
        issue(1'b0, 8'h10, '0, '0, 1'b0);
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        chk("mid_rst_ready", 288'(req_ready), 288'(1));
        for (int k = 0; k < 6; k++) begin
            chk("mid_rst_no_rsp", 288'(rsp_valid), 288'(0));
            @(negedge clock);
        end
        @(posedge clock); #1;

        // Single corrupted read: lane 3 flagged, counter steps once
        issue(1'b0, 8'h40, '0, '0, 1'b1);
        wait_rsp(lat);
        chk("flip_perr", 288'(rsp_perr), 288'(PAR ? 32'h8 : 32'h0));
        chk("flip_pcnt", 288'(perr_count), 288'(PAR ? 8'd1 : 8'd0));
        @(posedge clock); #1;

        // Many corrupted reads saturate the counter
        for (int n = 0; n < 300; n++) issue(1'b0, 8'h10, '0, '0, 1'b1);
        repeat (4) @(negedge clock);
        chk("pcnt_saturate", 288'(perr_count), 288'(PAR ? 8'd255 : 8'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_ctrl_256x288.md
SRAM_CTRL_256X288 -- requirements
Module: sram_ctrl_256x288

Interface
REQ-001 Parameter RSP_DEPTH, default 2, sets response FIFO entries; SHALL be a power of two, at least 2.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when high with req_valid.
REQ-006 req_write  input  1  1 = masked write, 0 = read.
REQ-007 req_addr  input  8  word address.
REQ-008 req_wdata  input  256  write data, byte i = bits [8i+7:8i].
REQ-009 req_wmask  input  32  per-byte write enable.
REQ-010 rsp_valid  output  1  read response present.
REQ-011 rsp_ready  input  1  consumer takes response when high with rsp_valid.
REQ-012 rsp_rdata  output  256  read data, byte i from SRAM bits [9i+7:9i].
REQ-013 rsp_perr  output  32  per-byte parity error flags for rsp_rdata.
REQ-014 perr_count  output  8  saturating count of responses with any parity error.
REQ-015 sram_valid, sram_write  output  1 each; sram_addr  output  8; sram_wdata  output  288; sram_wmask  output  32; sram_rdata  input  288 -- drive the 256x288 masked single-port SRAM (9-bit lanes, read data valid the cycle after a read issue and held until the next read).

Function
REQ-016 Accept = req_valid & req_ready; sram_valid SHALL equal accept combinationally, with sram_write/addr/wmask passed through unregistered.
REQ-017 req_ready SHALL be high iff fifo_count + inflight < RSP_DEPTH, independent of req_valid and req_write.
REQ-018 Write data mapping: sram_wdata[9i+7:9i] = req_wdata[8i+7:8i]; bit 9i+8 per REQ-030.
REQ-019 Writes produce no response; a write does not change inflight.
REQ-020 Read accepted in cycle T sets inflight for cycle T+1; in T+1 sram_rdata is pushed into the FIFO; rsp_valid high earliest in T+2 (fixed 2-cycle minimum latency).
REQ-021 Back-to-back reads: one per cycle, each response pushed in order; inflight stays set while consecutive reads issue.
REQ-022 FIFO: rsp_valid = count != 0; rsp_rdata/rsp_perr from head entry; pop on rsp_valid & rsp_ready.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo RSP_DEPTH.
REQ-024 Pop does not raise req_ready in the same cycle (no combinational ready path from rsp_ready).
REQ-025 Write at T followed by read of same address at T+1 SHALL return the written bytes for masked lanes and old bytes elsewhere.
REQ-026 Overflow SHALL be impossible by REQ-017; count never exceeds RSP_DEPTH.

Reset
REQ-027 On resetn low: count=0, pointers=0, inflight=0, perr_count=0, rsp_valid=0, sram_valid forced 0, req_ready=0 while asserted.
REQ-028 Reset mid-operation discards in-flight read and all buffered responses; no response emerges after release.
REQ-029 First cycle after release: req_ready=1, rsp_valid=0.

Configuration
REQ-030 Macro SRAM_PARITY_EN defined: sram_wdata bit 9i+8 = XOR of byte i (even parity); on push, rsp_perr[i] = XOR of sram_rdata[9i+8:9i]; perr_count increments by 1 per pushed response with nonzero rsp_perr, saturating at 255.
REQ-031 Macro SRAM_PARITY_EN undefined: bit 9i+8 written 0, rdata bit 9i+8 ignored, rsp_perr and perr_count tied 0, no parity logic present.

Verification
REQ-032 Write addr 0x10 data bytes 0x00..0x1F mask 0xFFFFFFFF, read 0x10 -> rsp_valid at T+2, rsp_rdata bytes 0x00..0x1F, rsp_perr 0.
REQ-033 Write 0x20 all 0xAA, then write 0x20 all 0x55 mask 0x0000FFFF, read -> bytes 0-15 = 0x55, bytes 16-31 = 0xAA.
REQ-034 rsp_ready held 0, four reads issued (RSP_DEPTH=2) -> only 2 accepted, req_ready 0 thereafter; release rsp_ready -> 2 responses in issue order, then req_ready 1.
REQ-035 SRAM_PARITY_EN, model flips sram_rdata bit 9*3 on one read -> rsp_perr = 0x00000008, perr_count = 1; 300 such reads -> perr_count = 255.
REQ-036 Assert resetn low cycle after read issue -> no response after release, req_ready=1, count=0.
